sdram_req_arbiter: RTL
======================

// Module: sdram_req_arbiter
// PURPOSE
//  Arbitrates the single SDRAM_16bit command port between the video refill path (vqueue) and cache line
//  write-back/fill (cache_controller). Issues sys_CMD/sys_ADDR, holds each command until acknowledged,
//  counts data beats to find transfer end, packs 16-bit video beats into 32-bit vqueue words, and steers
//  data-valid strobes to the cache. Runs in the SDRAM clock domain, between the cache/vqueue and SDRAM_16bit.
// PARAMETERS
//  VID_BASE     15'h6FF8  framebuffer base, in 8-word SDRAM block units
//  VID_LAST     12'd3071  last video pointer value (32-byte bursts per frame minus 1)
//  VID_BEATS    16        16-bit beats per video read (32 bytes)
//  LINE_BEATS   128       16-bit beats per cache line transfer (256 bytes)
// PORTS
//  clk             in   1   SDRAM-domain clock; sole clock
//  rst             in   1   synchronous, active-high reset
//  vq_almost_empty in   1   video queue wants a refill
//  vid_restart     in   1   pulse: restart frame fetch at pointer 0
//  cache_wr_req    in   1   dirty line write-back request (level, held until served)
//  cache_wr_blk    in   12  write-back line address (256-byte units)
//  cache_rd_req    in   1   line fill request (level, held until served)
//  cache_rd_blk    in   12  fill line address (256-byte units)
//  sys_cmd         out  2   00 nop, 01 write 256B, 10 read 32B, 11 read 256B
//  sys_addr        out  18  SDRAM word address of current command
//  sys_cmd_ack     in   2   echo of command being accepted; 00 otherwise
//  sys_rd_valid    in   1   read beat valid on sys_dout
//  sys_wr_valid    in   1   write beat consumed
//  sys_dout        in   16  SDRAM read data
//  cache_fill_we   out  1   = sys_rd_valid during cache fill transfer
//  cache_drain_re  out  1   = sys_wr_valid during cache write-back transfer
//  vq_wr_en        out  1   one-cycle push to vqueue
//  vq_data         out  32  {second beat, first beat}
//  vid_ptr         out  12  current video burst pointer
//  busy            out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; sys_cmd=00; sys_addr=0; vid_ptr=0; beat count=0; pack phase=0; restart flag=0;
//   all strobes 0; vq_data=0. Reset mid-transfer abandons it; beats arriving in IDLE are ignored.
//  States: IDLE -> ISSUE -> XFER -> IDLE.
//  IDLE: pick by priority vq_almost_empty > cache_wr_req > cache_rd_req; register sys_cmd/sys_addr and
//   owner (VID/WB/FILL), go ISSUE next cycle. No request: stay, sys_cmd=00.
//  ISSUE: hold sys_cmd/sys_addr stable until sys_cmd_ack!=00. On that edge: sys_cmd<=00, beat count<=0,
//   go XFER. If owner VID: vid_ptr <= (vid_ptr==VID_LAST)?0:vid_ptr+1.
//  XFER: count sys_rd_valid (VID, FILL) or sys_wr_valid (WB). After beat VID_BEATS / LINE_BEATS -> IDLE.
//   Other valid kind in XFER is ignored.
//  Addresses: WB {cache_wr_blk,6'b0}; FILL {cache_rd_blk,6'b0};
//   VID {(VID_BASE+{3'b0,~vid_ptr[11:2],vid_ptr[1:0]}) mod 2^15, 3'b000} (row field inverted: bottom-up).
//  Packing (VID only): phase 0 beat -> low half held; phase 1 beat -> vq_data={sys_dout,held}, vq_wr_en=1
//   for that cycle. Phase toggles per beat; cleared on entering XFER.
//  cache_fill_we / cache_drain_re are combinational gates of valids by owner and state XFER; latency 0.
//  vid_restart: sets flag; in IDLE with flag set, vid_ptr<=0, flag cleared, before arbitration that cycle.
//   Restart during a VID transfer does not abort it.
//  Simultaneous wr and rd requests: write-back served first, so a dirty victim leaves before the fill.
//  One command outstanding at a time; new request seen only in IDLE.
// STRUCTURE
//  Shared package: SDRAM command codes (CMD_NOP/WR256/RD32/RD256), owner enum, state enum, beat constants.
//  One natural sub-module: vid_pack16to32 (phase flop, low-half register, push strobe).
// TESTING
//  1 Reset, vq_almost_empty=1 -> sys_cmd=10, sys_addr=18'h3FFA0; ack 10 -> vid_ptr=1, 16 beats -> 8 vq_wr_en.
//  2 Beats 16'h1111,16'h2222 -> vq_data=32'h2222_1111, single vq_wr_en pulse on second beat.
//  3 vid_ptr=3071 request -> sys_addr=18'h39FD8; after ack vid_ptr=0.
//  4 cache_wr_req+cache_rd_req+vq_almost_empty together -> order RD32, WR256, RD256; 128 cache_drain_re.
//  5 Ack delayed 10 cycles -> sys_cmd/sys_addr stable throughout; sys_cmd=00 cycle after ack.
//  6 rst mid FILL at beat 40 -> IDLE, strobes 0, remaining 88 beats produce no cache_fill_we.

Source files
------------

// File: rtl/sdram_req_arbiter_pkg.sv
// Shared types and constants for the SDRAM command-port arbiter.
package sdram_req_arbiter_pkg;

    localparam int unsigned SYS_ADDR_W = 18;
    localparam int unsigned BLK_W      = 12;
    localparam int unsigned PTR_W      = 12;
    localparam int unsigned ROW_W      = 15;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned VQ_W       = 32;
    localparam int unsigned VID_BEATS  = 16;
    localparam int unsigned LINE_BEATS = 128;

    localparam logic [ROW_W-1:0] VID_BASE = 15'h6FF8;
    localparam logic [PTR_W-1:0] VID_LAST = 12'd3071;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_WR256 = 2'b01,
        CMD_RD32  = 2'b10,
        CMD_RD256 = 2'b11
    } sys_cmd_e;

    typedef enum logic [1:0] {OWN_VID, OWN_WB, OWN_FILL} owner_e;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_XFER} state_e;

    typedef struct packed {
        sys_cmd_e              cmd;
        logic [SYS_ADDR_W-1:0] addr;
    } sys_req_t;

    // Framebuffer rows are fetched bottom-up, so the row field of the pointer is inverted.
    function automatic logic [SYS_ADDR_W-1:0] vid_addr(input logic [PTR_W-1:0] ptr);
        logic [ROW_W-1:0] blk;
        blk = VID_BASE + {3'b000, ~ptr[11:2], ptr[1:0]};
        return {blk, 3'b000};
    endfunction

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// Command/data bus between the arbiter and the SDRAM_16bit controller.
interface sdram_req_arbiter_if;
    import sdram_req_arbiter_pkg::*;

    logic [1:0]            sys_cmd;
    logic [SYS_ADDR_W-1:0] sys_addr;
    logic [1:0]            sys_cmd_ack;
    logic                  sys_rd_valid;
    logic                  sys_wr_valid;
    logic [DATA_W-1:0]     sys_dout;

    modport master (
        output sys_cmd, sys_addr,
        input  sys_cmd_ack, sys_rd_valid, sys_wr_valid, sys_dout
    );

    modport slave (
        input  sys_cmd, sys_addr,
        output sys_cmd_ack, sys_rd_valid, sys_wr_valid, sys_dout
    );
endinterface

// File: rtl/sdram_req_arbiter_vid_pack16to32.sv
// Packs pairs of 16-bit video beats into one 32-bit vqueue word (first beat in the low half).
module sdram_req_arbiter_vid_pack16to32
    import sdram_req_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              beat,
    input  logic [DATA_W-1:0] din,
    output logic              wr_en,
    output logic [VQ_W-1:0]   data
);

    logic              phase_q, phase_d;
    logic [DATA_W-1:0] low_q, low_d;
    logic              wr_en_q, wr_en_d;
    logic [VQ_W-1:0]   data_q, data_d;

    // Hold the first beat, emit the word on the second.
    always_comb begin
        phase_d = phase_q;
        low_d   = low_q;
        wr_en_d = 1'b0;
        data_d  = data_q;
        if (clr) begin
            phase_d = 1'b0;
        end else if (beat) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                low_d = din;
            end else begin
                wr_en_d = 1'b1;
                data_d  = {din, low_q};
            end
        end
    end

    // Packer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
            low_q   <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
        end else begin
            phase_q <= phase_d;
            low_q   <= low_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
        end
    end

    assign wr_en = wr_en_q;
    assign data  = data_q;

endmodule

// File: rtl/sdram_req_arbiter.sv
// Single-command arbiter in front of SDRAM_16bit: video refill, cache write-back, cache fill.
module sdram_req_arbiter
    import sdram_req_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                vq_almost_empty,
    input  logic                vid_restart,
    input  logic                cache_wr_req,
    input  logic [BLK_W-1:0]    cache_wr_blk,
    input  logic                cache_rd_req,
    input  logic [BLK_W-1:0]    cache_rd_blk,
    sdram_req_arbiter_if.master sys,
    output logic                cache_fill_we,
    output logic                cache_drain_re,
    output logic                vq_wr_en,
    output logic [VQ_W-1:0]     vq_data,
    output logic [PTR_W-1:0]    vid_ptr,
    output logic                busy
);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    sys_req_t         req_q, req_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_now;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
    logic             restart_q, restart_d;
    logic             beat_c, xfer_start_c, vid_beat_c;

    // Qualify beats for the current owner and detect command acceptance.
    always_comb begin
        cnt_last     = (owner_q == OWN_VID) ? CNT_W'(VID_BEATS - 1) : CNT_W'(LINE_BEATS - 1);
        beat_c       = (state_q == ST_XFER) &&
                       ((owner_q == OWN_WB) ? sys.sys_wr_valid : sys.sys_rd_valid);
        xfer_start_c = (state_q == ST_ISSUE) && (sys.sys_cmd_ack != 2'b00);
        vid_beat_c   = beat_c && (owner_q == OWN_VID);
    end

    // Next-state: arbitration, command hold, beat counting, video pointer.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        req_d     = req_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        restart_d = restart_q | vid_restart;
        ptr_now   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (restart_q) begin
                    ptr_now   = '0;
                    ptr_d     = '0;
                    restart_d = vid_restart;
                end
                req_d.cmd = CMD_NOP;
                if (vq_almost_empty) begin
                    req_d   = '{cmd: CMD_RD32, addr: vid_addr(ptr_now)};
                    owner_d = OWN_VID;
                    state_d = ST_ISSUE;
                end else if (cache_wr_req) begin
                    req_d   = '{cmd: CMD_WR256, addr: {cache_wr_blk, 6'b000000}};
                    owner_d = OWN_WB;
                    state_d = ST_ISSUE;
                end else if (cache_rd_req) begin
                    req_d   = '{cmd: CMD_RD256, addr: {cache_rd_blk, 6'b000000}};
                    owner_d = OWN_FILL;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (xfer_start_c) begin
                    req_d.cmd = CMD_NOP;
                    cnt_d     = '0;
                    state_d   = ST_XFER;
                    if (owner_q == OWN_VID) begin
                        ptr_d = (ptr_q == VID_LAST) ? '0 : ptr_q + PTR_W'(1);
                    end
                end
            end
            ST_XFER: begin
                if (beat_c) begin
                    if (cnt_q == cnt_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_VID;
            req_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            req_q     <= req_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            restart_q <= restart_d;
        end
    end

    sdram_req_arbiter_vid_pack16to32 u_pack (
        .clk   (clk),
        .rst   (rst),
        .clr   (xfer_start_c),
        .beat  (vid_beat_c),
        .din   (sys.sys_dout),
        .wr_en (vq_wr_en),
        .data  (vq_data)
    );

    assign sys.sys_cmd    = req_q.cmd;
    assign sys.sys_addr   = req_q.addr;
    assign vid_ptr        = ptr_q;
    assign busy           = (state_q != ST_IDLE);
    assign cache_fill_we  = sys.sys_rd_valid && (state_q == ST_XFER) && (owner_q == OWN_FILL);
    assign cache_drain_re = sys.sys_wr_valid && (state_q == ST_XFER) && (owner_q == OWN_WB);

endmodule
